// File: rtl/gamma1_sampler_arbiter_if.sv
// Purpose: requester and core-side bus of the shared gamma1 sampler arbiter.
// Latency: none (signal bundle only).
// Backpressure: level req/done per requester, level start/done toward the core.
// Ports: req/seed/nonce/done per requester, grant, a_out, abort_err,
//        core_start/core_seed/core_nonce to the core, core_a/core_done back.
interface gamma1_sampler_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int SEED_W = 512,
    parameter int POLY_W = 8192
);
    logic              req0;
    logic [SEED_W-1:0] seed0;
    logic [15:0]       nonce0;
    logic              done0;
    logic              req1;
    logic [SEED_W-1:0] seed1;
    logic [15:0]       nonce1;
    logic              done1;
    logic [N_REQ-1:0]  grant;
    logic [POLY_W-1:0] a_out;
    logic [N_REQ-1:0]  abort_err;
    logic              core_start;
    logic [SEED_W-1:0] core_seed;
    logic [15:0]       core_nonce;
    logic [POLY_W-1:0] core_a;
    logic              core_done;

    // Arbiter side.
    modport slave (
        input  req0, seed0, nonce0, req1, seed1, nonce1, core_a, core_done,
        output done0, done1, grant, a_out, abort_err,
               core_start, core_seed, core_nonce
    );

    // Requesters plus core side.
    modport master (
        output req0, seed0, nonce0, req1, seed1, nonce1, core_a, core_done,
        input  done0, done1, grant, a_out, abort_err,
               core_start, core_seed, core_nonce
    );
endinterface

// File: rtl/gamma1_sampler_arbiter.sv
// Purpose: round-robin share of one poly_uniform_gamma1 core between two requesters.
// Latency: grant/core_start at the req-sampling edge; done one edge after core_done.
// Backpressure: owner holds req until done seen; result held on a_out until req drops.
// Ports: clock, reset (sync, active-high) and bus (slave modport): requester
//        req/seed/nonce/done, grant, a_out, abort_err and the core start/done link.
module gamma1_sampler_arbiter #(
    parameter int N_REQ  = 2,
    parameter int SEED_W = 512,
    parameter int POLY_W = 8192
) (
    input  logic                    clock,
    input  logic                    reset,
    gamma1_sampler_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              owner;
    logic              rr_ptr;
    logic [N_REQ-1:0]  grant_q;
    logic [N_REQ-1:0]  done_q;
    logic [N_REQ-1:0]  abort_q;
    logic [POLY_W-1:0] a_q;
    logic [SEED_W-1:0] seed_q;
    logic [15:0]       nonce_q;

    logic owner_req;
    logic load;
    logic winner;
    logic capture;
    logic abort;
    logic release_own;

    assign owner_req = owner ? bus.req1 : bus.req0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        load        = 1'b0;
        winner      = rr_ptr;
        capture     = 1'b0;
        abort       = 1'b0;
        release_own = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    load      = 1'b1;
                    // On a tie the requester that did not win last time goes first.
                    winner    = (bus.req0 && bus.req1) ? ~rr_ptr : bus.req1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!owner_req) begin
                    abort     = 1'b1;
                    // A core_done coinciding with the drop is the drain itself.
                    state_nxt = bus.core_done ? GAP : DRAIN;
                end else if (bus.core_done) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            DRAIN: begin
                if (bus.core_done) begin
                    state_nxt = GAP;
                end
            end
            HOLD: begin
                if (!owner_req) begin
                    release_own = 1'b1;
                    state_nxt   = GAP;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner   <= 1'b0;
            rr_ptr  <= 1'b0;
            grant_q <= '0;
            done_q  <= '0;
            abort_q <= '0;
            a_q     <= '0;
            seed_q  <= '0;
            nonce_q <= '0;
        end else begin
            if (load) begin
                owner   <= winner;
                rr_ptr  <= winner;
                grant_q <= winner ? 2'b10 : 2'b01;
                seed_q  <= winner ? bus.seed1 : bus.seed0;
                nonce_q <= winner ? bus.nonce1 : bus.nonce0;
            end
            // Ownership ends on every path into GAP, so the core idles unowned.
            if (state_nxt == GAP && state != GAP) begin
                grant_q <= '0;
            end
            if (capture) begin
                a_q           <= bus.core_a;
                done_q[owner] <= 1'b1;
            end
            if (release_own) begin
                done_q <= '0;
            end
            if (abort) begin
                abort_q[owner] <= 1'b1;
            end
        end
    end

    assign bus.core_start = (state == RUN) && !bus.core_done;
    assign bus.core_seed  = seed_q;
    assign bus.core_nonce = nonce_q;
    assign bus.grant      = grant_q;
    assign bus.done0      = done_q[0];
    assign bus.done1      = done_q[1];
    assign bus.abort_err  = abort_q;
    assign bus.a_out      = a_q;

endmodule

// File: tb/tb_gamma1_sampler_arbiter.sv
module tb_gamma1_sampler_arbiter;
    localparam int N_REQ  = 2;
    localparam int SEED_W = 512;
    localparam int POLY_W = 8192;
    localparam int CORE_CYC = 20;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    gamma1_sampler_arbiter_if #(.N_REQ(N_REQ), .SEED_W(SEED_W), .POLY_W(POLY_W)) bus ();

    gamma1_sampler_arbiter #(.N_REQ(N_REQ), .SEED_W(SEED_W), .POLY_W(POLY_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [POLY_W-1:0] core_fn(input logic [SEED_W-1:0] s, input logic [15:0] n);
        return {16{s ^ {32{n}}}};
    endfunction

    // Core model: once started it runs CORE_CYC cycles, then holds done while start stays high.
    logic       busy;
    int         ccnt;
    always @(posedge clock) begin
        if (reset) begin
            busy          <= 1'b0;
            ccnt          <= 0;
            bus.core_done <= 1'b0;
        end else if (bus.core_done) begin
            if (!bus.core_start) bus.core_done <= 1'b0;
        end else if (busy) begin
            if (ccnt == CORE_CYC - 1) begin
                bus.core_done <= 1'b1;
                bus.core_a    <= core_fn(bus.core_seed, bus.core_nonce);
                busy          <= 1'b0;
            end else begin
                ccnt <= ccnt + 1;
            end
        end else if (bus.core_start) begin
            busy <= 1'b1;
            ccnt <= 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [POLY_W-1:0] last_a;

    task automatic set_req(input int who, input logic v);
        if (who == 1) bus.req1 = v;
        else          bus.req0 = v;
    endtask

    // Entered at the negedge right after the grant edge; leaves at the GAP negedge.
    task automatic serve(input int who, input bit drop_other);
        logic [15:0]       nexp;
        logic [SEED_W-1:0] sexp;
        logic [POLY_W-1:0] aexp;
        logic [1:0]        dexp;
        int                n;
        nexp = (who == 1) ? bus.nonce1 : bus.nonce0;
        sexp = (who == 1) ? bus.seed1 : bus.seed0;
        aexp = core_fn(sexp, nexp);
        dexp = (who == 1) ? 2'b10 : 2'b01;
        chk("grant", 64'(bus.grant), 64'(dexp));
        chk("core_nonce", 64'(bus.core_nonce), 64'(nexp));
        chk("core_seed_lo", bus.core_seed[63:0], sexp[63:0]);
        n = 0;
        while (bus.core_start && n < 100) begin
            n++;
            // Disturb the non-owner's nonce while the core is owned.
            if (n == 3) begin
                if (who == 1) bus.nonce0 = bus.nonce0 + 16'h1111;
                else          bus.nonce1 = bus.nonce1 + 16'h1111;
            end
            @(negedge clock);
        end
        chk("start_cycles", 64'(n), 64'(CORE_CYC));
        chk("core_nonce_held", 64'(bus.core_nonce), 64'(nexp));
        chk("core_done_seen", 64'(bus.core_done), 64'd1);
        chk("done_not_early", 64'({bus.done1, bus.done0}), 64'd0);
        @(negedge clock);
        chk("done_set", 64'({bus.done1, bus.done0}), 64'(dexp));
        chk("a_out_lo", bus.a_out[63:0], aexp[63:0]);
        chk("a_out_hi", bus.a_out[POLY_W-1 -: 64], aexp[POLY_W-1 -: 64]);
        chk("a_out_full", 64'(bus.a_out == aexp), 64'd1);
        last_a = aexp;
        @(negedge clock);
        chk("done_held", 64'({bus.done1, bus.done0}), 64'(dexp));
        set_req(who, 1'b0);
        if (drop_other) set_req(1 - who, 1'b0);
        @(negedge clock);
        chk("done_clr", 64'({bus.done1, bus.done0}), 64'd0);
        chk("gap_grant", 64'(bus.grant), 64'd0);
        chk("gap_start", 64'(bus.core_start), 64'd0);
    endtask

    initial begin
        int who;
        int n;
        bus.req0   = 1'b0;
        bus.req1   = 1'b0;
        bus.seed0  = {16{32'hA5A5_0001}};
        bus.seed1  = {16{32'h5A5A_1002}};
        bus.nonce0 = 16'h0005;
        bus.nonce1 = 16'h0200;
        bus.core_a = '0;
        last_a     = '0;
        repeat (2) @(negedge clock);

        // Reset state.
        chk("rst_grant", 64'(bus.grant), 64'd0);
        chk("rst_done", 64'({bus.done1, bus.done0}), 64'd0);
        chk("rst_start", 64'(bus.core_start), 64'd0);
        chk("rst_abort", 64'(bus.abort_err), 64'd0);
        chk("rst_a_out", 64'(|bus.a_out), 64'd0);
        chk("rst_nonce", 64'(bus.core_nonce), 64'd0);
        chk("rst_seed", 64'(|bus.core_seed), 64'd0);
        reset = 1'b0;

        // Single request from requester 0.
        bus.req0 = 1'b1;
        @(negedge clock);
        serve(0, 1'b0);

        // Reset pulsed mid-RUN, then a fresh request is served.
        bus.nonce0 = 16'h0007;
        bus.req0   = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("pre_rst_grant", 64'(bus.grant), 64'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_grant", 64'(bus.grant), 64'd0);
        chk("mid_rst_start", 64'(bus.core_start), 64'd0);
        chk("mid_rst_nonce", 64'(bus.core_nonce), 64'd0);
        chk("mid_rst_a_out", 64'(|bus.a_out), 64'd0);
        chk("mid_rst_done", 64'({bus.done1, bus.done0}), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        serve(0, 1'b0);

        // Simultaneous requests after reset, then six alternating jobs.
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        bus.nonce0 = 16'h0100;
        bus.nonce1 = 16'h0200;
        bus.req0   = 1'b1;
        bus.req1   = 1'b1;
        @(negedge clock);
        who = 1;
        for (int j = 0; j < 6; j++) begin
            serve(who, j == 5);
            if (j < 5) begin
                set_req(who, 1'b1);
                @(negedge clock);
                chk("idle_grant", 64'(bus.grant), 64'd0);
                chk("idle_start", 64'(bus.core_start), 64'd0);
                @(negedge clock);
            end
            who = 1 - who;
        end
        @(negedge clock);

        // Abort: requester 1 drops req five cycles into RUN.
        bus.req1 = 1'b1;
        @(negedge clock);
        chk("ab_grant", 64'(bus.grant), 64'd2);
        repeat (4) @(negedge clock);
        bus.req1 = 1'b0;
        @(negedge clock);
        chk("ab_err", 64'(bus.abort_err), 64'd2);
        chk("ab_drain_start", 64'(bus.core_start), 64'd0);
        bus.req0 = 1'b1;
        n = 0;
        while (!bus.core_done && n < 100) begin
            chk("ab_drain_start_low", 64'(bus.core_start), 64'd0);
            n++;
            @(negedge clock);
        end
        chk("ab_drain_done", 64'(bus.core_done), 64'd1);
        @(negedge clock);
        chk("ab_gap_grant", 64'(bus.grant), 64'd0);
        chk("ab_done1", 64'(bus.done1), 64'd0);
        chk("ab_a_out_kept", 64'(bus.a_out == last_a), 64'd1);
        @(negedge clock);
        chk("ab_idle_grant", 64'(bus.grant), 64'd0);
        @(negedge clock);
        serve(0, 1'b0);
        chk("ab_err_sticky", 64'(bus.abort_err), 64'd2);
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
